// File: rtl/rv32_pkg.sv
// Shared RV32 fetch definitions: widths, NOP encoding, reset PC default and the queue entry layout.
package rv32_pkg;

    localparam int XLEN = 32;
    localparam int ILEN = 32;

    localparam logic [ILEN-1:0] NOP_INSTR    = 32'h0000_0013;
    localparam logic [XLEN-1:0] RESET_PC_DEF = 32'h0000_0000;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] instr;
    } fq_entry_t;

    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] a);
        return {a[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_queue_if.sv
// Fetch unit bundle: imem request/response channel, decode handshake and execute redirect.
interface fetch_queue_if;
    import rv32_pkg::*;

    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_resp_valid;
    logic [ILEN-1:0] imem_resp_data;
    logic            instr_valid;
    logic            instr_ready;
    logic [ILEN-1:0] instr_out;
    logic [XLEN-1:0] pc_out;
    logic            redirect;
    logic [XLEN-1:0] redirect_pc;

    modport master (
        output imem_req_valid, imem_req_addr, instr_valid, instr_out, pc_out,
        input  imem_req_ready, imem_resp_valid, imem_resp_data, instr_ready, redirect, redirect_pc
    );

    modport slave (
        input  imem_req_valid, imem_req_addr, instr_valid, instr_out, pc_out,
        output imem_req_ready, imem_resp_valid, imem_resp_data, instr_ready, redirect, redirect_pc
    );

endinterface

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with count; push and pop in the same cycle are legal even when full.
// Data visible one cycle after push; push while full without pop and pop while empty are ignored.
module fetch_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_push_dat,
    input  logic                       i_pop,
    input  logic                       i_flush,
    output logic [WIDTH-1:0]           o_dat,
    output logic [$clog2(DEPTH+1)-1:0] o_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;

    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_pop;

    assign w_full  = (r_count == CW'(DEPTH));
    assign w_empty = (r_count == '0);
    assign w_pop   = i_pop && !w_empty;
    assign w_push  = i_push && (!w_full || w_pop);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push && !i_flush) r_mem[r_wr_ptr] <= i_push_dat;
    end

    assign o_dat   = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule

// File: rtl/fetch_queue.sv
// Instruction prefetch queue: issues sequential imem fetches under a credit limit, buffers {pc,instr} for decode.
// Req->instr_valid = imem latency + 1; decode stalls back-pressure via reserved credits, redirect flushes and drops in-flight beats.
module fetch_queue
    import rv32_pkg::*;
#(
    parameter int              DEPTH    = 4,
    parameter int              MAX_OUT  = 2,
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEF
) (
    input  logic          clk,
    input  logic          rst,
    fetch_queue_if.master bus
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int OW = $clog2(MAX_OUT + 1);
    localparam int TW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;

    logic [XLEN-1:0] r_fetch_pc;
    logic [OW-1:0]   r_out_cnt;
    logic [OW-1:0]   r_drop_cnt;
    logic [XLEN-1:0] r_tag_mem [MAX_OUT];
    logic [TW-1:0]   r_tag_wr;
    logic [TW-1:0]   r_tag_rd;

    logic [CW-1:0]   w_occ;
    logic [CW:0]     w_credit;
    logic            w_req_vld;
    logic            w_req_hs;
    logic            w_resp_any;
    logic            w_resp_keep;
    logic            w_pop;
    logic            w_instr_vld;
    logic [OW-1:0]   w_out_nxt;
    fq_entry_t       w_push_dat;
    fq_entry_t       w_head;

    function automatic logic [TW-1:0] tag_inc(input logic [TW-1:0] p);
        return (p == TW'(MAX_OUT - 1)) ? '0 : p + 1'b1;
    endfunction

    // Queued entries plus in-flight requests must fit, so every response has a slot.
    assign w_credit  = (CW+1)'(w_occ) + (CW+1)'(r_out_cnt);
    assign w_req_vld = rst && !bus.redirect && (r_drop_cnt == '0)
                       && (r_out_cnt < OW'(MAX_OUT))
                       && (w_credit < (CW+1)'(DEPTH));
    assign w_req_hs  = w_req_vld && bus.imem_req_ready;

    // A beat with nothing outstanding cannot belong to us; ignoring it keeps the counters sane.
    assign w_resp_any  = bus.imem_resp_valid && (r_out_cnt != '0);
    assign w_resp_keep = w_resp_any && (r_drop_cnt == '0) && !bus.redirect;

    assign w_instr_vld = (w_occ != '0);
    assign w_pop       = w_instr_vld && bus.instr_ready && !bus.redirect;

    always_comb begin
        w_out_nxt = r_out_cnt;
        case ({w_req_hs, w_resp_any})
            2'b10:   w_out_nxt = r_out_cnt + 1'b1;
            2'b01:   w_out_nxt = r_out_cnt - 1'b1;
            default: w_out_nxt = r_out_cnt;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_fetch_pc <= RESET_PC;
            r_out_cnt  <= '0;
            r_drop_cnt <= '0;
            r_tag_wr   <= '0;
            r_tag_rd   <= '0;
        end else begin
            r_out_cnt <= w_out_nxt;
            if (bus.redirect) begin
                r_fetch_pc <= word_align(bus.redirect_pc);
                r_drop_cnt <= r_out_cnt - OW'(w_resp_any);
                r_tag_wr   <= '0;
                r_tag_rd   <= '0;
            end else begin
                if (w_req_hs) begin
                    r_fetch_pc <= r_fetch_pc + 32'd4;
                    r_tag_wr   <= tag_inc(r_tag_wr);
                end
                if (w_resp_any && (r_drop_cnt != '0)) r_drop_cnt <= r_drop_cnt - 1'b1;
                if (w_resp_keep)                      r_tag_rd   <= tag_inc(r_tag_rd);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_req_hs) r_tag_mem[r_tag_wr] <= r_fetch_pc;
    end

    assign w_push_dat.pc    = r_tag_mem[r_tag_rd];
    assign w_push_dat.instr = bus.imem_resp_data;

    fetch_fifo #(
        .WIDTH ($bits(fq_entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .i_push     (w_resp_keep),
        .i_push_dat (w_push_dat),
        .i_pop      (w_pop),
        .i_flush    (bus.redirect),
        .o_dat      (w_head),
        .o_count    (w_occ)
    );

    assign bus.imem_req_valid = w_req_vld;
    assign bus.imem_req_addr  = r_fetch_pc;
    assign bus.instr_valid    = w_instr_vld;
    assign bus.instr_out      = w_instr_vld ? w_head.instr : NOP_INSTR;
    assign bus.pc_out         = w_instr_vld ? w_head.pc    : '0;

endmodule
